// File: rtl/dehaze_atmos_ctrl.sv
// dehaze_atmos_ctrl: per-frame dark-channel max/size measurement publishing atmospheric light A.
// Optional temporal smoothing of A when DEHAZE_ATMOS_IIR_EN is defined.
module dehaze_atmos_ctrl #(
  parameter int                DATA_W = 8,
  parameter int                CNT_W  = 12,
  parameter logic [DATA_W-1:0] A_MIN  = 8'd180,
  parameter logic [DATA_W-1:0] A_INIT = 8'd255
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_min,
  input  logic              i_vsync,
  input  logic              i_de,
  output logic [DATA_W-1:0] o_atmos,
  output logic              o_atmos_valid,
  output logic              o_frame_done,
  output logic [CNT_W-1:0]  o_width,
  output logic [CNT_W-1:0]  o_height,
  output logic [CNT_W-1:0]  o_frame_cnt
);
  typedef enum logic [1:0] {S_WAIT, S_ACC, S_UPD} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_max, r_atmos, w_clamp, w_pub;
  logic [CNT_W-1:0]  r_col, r_row, r_line_w, r_width, r_height, r_fcnt;
  logic              r_vs_d, r_deg_d, r_valid, r_done;
  logic              w_vs_rise, w_deg, w_deg_fall;
  assign w_vs_rise  = i_vsync & ~r_vs_d;
  assign w_deg      = i_de & ~i_vsync;
  assign w_deg_fall = r_deg_d & ~w_deg;
  assign w_clamp    = (r_max > A_MIN) ? r_max : A_MIN;
`ifdef DEHAZE_ATMOS_IIR_EN
  logic [DATA_W+1:0] w_sum;
  assign w_sum = {1'b0, r_atmos, 1'b0} + {2'b0, r_atmos} + {2'b0, w_clamp} + (DATA_W+2)'(2);
  // the first frame after reset has no history to blend with
  assign w_pub = r_valid ? w_sum[DATA_W+1:2] : w_clamp;
`else
  assign w_pub = w_clamp;
`endif
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_WAIT;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_UPD) ? S_ACC :
             !w_vs_rise         ? r_state :
             (r_state == S_WAIT) ? S_ACC : S_UPD;
  end
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_d   <= 1'b0;
      r_deg_d  <= 1'b0;
      r_max    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_line_w <= '0;
      r_atmos  <= A_INIT;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_width  <= '0;
      r_height <= '0;
      r_fcnt   <= '0;
    end else begin
      r_vs_d  <= i_vsync;
      r_deg_d <= w_deg;
      r_done  <= 1'b0;
      if (r_state == S_WAIT) begin
        if (w_vs_rise) begin
          r_max <= '0;
          r_col <= '0;
          r_row <= '0;
        end
      end else if (r_state == S_ACC) begin
        if (w_deg) begin
          r_max <= (i_min > r_max) ? i_min : r_max;
          r_col <= (&r_col) ? r_col : r_col + 1'b1;
        end
        // a line closed by vsync still falls here in the vs_rise cycle
        if (w_deg_fall) begin
          r_line_w <= r_col;
          r_col    <= '0;
          r_row    <= (&r_row) ? r_row : r_row + 1'b1;
        end
      end else begin
        r_atmos  <= w_pub;
        r_width  <= r_line_w;
        r_height <= r_row;
        r_done   <= 1'b1;
        r_valid  <= 1'b1;
        r_fcnt   <= (&r_fcnt) ? r_fcnt : r_fcnt + 1'b1;
        r_max    <= '0;
        r_col    <= '0;
        r_row    <= '0;
        r_line_w <= '0;
      end
    end
  end
  assign o_atmos       = r_atmos;
  assign o_atmos_valid = r_valid;
  assign o_frame_done  = r_done;
  assign o_width       = r_width;
  assign o_height      = r_height;
  assign o_frame_cnt   = r_fcnt;
endmodule

// File: tb/tb_dehaze_atmos_ctrl.sv
// tb_dehaze_atmos_ctrl: directed frames against a small model of the published A.
module tb_dehaze_atmos_ctrl;
  logic        pixelclk = 1'b0;
  logic        reset_n;
  logic [7:0]  i_min;
  logic        i_vsync, i_de;
  logic [7:0]  o_atmos;
  logic        o_atmos_valid, o_frame_done;
  logic [11:0] o_width, o_height, o_frame_cnt;
  int n_checks = 0;
  int n_errors = 0;
  int exp_a    = 255;
  bit exp_v    = 1'b0;
  int exp_cnt  = 0;
  dehaze_atmos_ctrl dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_min(i_min), .i_vsync(i_vsync), .i_de(i_de),
    .o_atmos(o_atmos), .o_atmos_valid(o_atmos_valid), .o_frame_done(o_frame_done),
    .o_width(o_width), .o_height(o_height), .o_frame_cnt(o_frame_cnt)
  );
  always #5 pixelclk = ~pixelclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_pub(input int m);
    int clamp;
    clamp = (m > 180) ? m : 180;
`ifdef DEHAZE_ATMOS_IIR_EN
    exp_a = exp_v ? (3 * exp_a + clamp + 2) >> 2 : clamp;
`else
    exp_a = clamp;
`endif
    exp_v   = 1'b1;
    exp_cnt = exp_cnt + 1;
  endtask
  task automatic chk_reset();
    chk("rst_atmos", o_atmos, 255);
    chk("rst_valid", o_atmos_valid, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_width", o_width, 0);
    chk("rst_height", o_height, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    exp_a = 255;
    exp_v = 1'b0;
    exp_cnt = 0;
  endtask
  task automatic chk_pub(input int w, input int h);
    chk("atmos", o_atmos, exp_a);
    chk("valid", o_atmos_valid, exp_v);
    chk("width", o_width, w);
    chk("height", o_height, h);
    chk("frame_cnt", o_frame_cnt, exp_cnt);
  endtask
  // rows x cols of i_min = r*mult+c, one pixel optionally forced; last_open leaves de high
  task automatic frame(input int rows, input int cols, input int mult,
                       input int fr, input int fc, input int fv, input bit last_open);
    for (int r = 0; r < rows; r++) begin
      i_de = 1'b0;
      repeat (2) @(negedge pixelclk);
      for (int c = 0; c < cols; c++) begin
        i_de  = 1'b1;
        i_min = 8'((r == fr && c == fc) ? fv : r * mult + c);
        @(negedge pixelclk);
      end
    end
    if (!last_open) i_de = 1'b0;
  endtask
  // vsync with 250 on i_min; any open line keeps de for 3 cycles into vsync
  task automatic vsync(input bit pub);
    i_vsync = 1'b1;
    i_min   = 8'd250;
    for (int k = 1; k <= 4; k++) begin
      @(negedge pixelclk);
      chk("frame_done", o_frame_done, (pub && k == 2) ? 1 : 0);
      if (k == 3) i_de = 1'b0;
    end
    i_vsync = 1'b0;
    repeat (2) @(negedge pixelclk);
  endtask
  initial begin
    reset_n = 1'b0;
    i_min   = '0;
    i_vsync = 1'b0;
    i_de    = 1'b0;
    repeat (3) @(negedge pixelclk);
    chk_reset();
    reset_n = 1'b1;
    @(negedge pixelclk);
    frame(4, 6, 10, 2, 3, 230, 0);
    vsync(0);
    chk("arm_atmos", o_atmos, 255);
    chk("arm_valid", o_atmos_valid, 0);
    chk("arm_cnt", o_frame_cnt, 0);
    frame(4, 6, 10, 2, 3, 230, 0);
    model_pub(230);
    vsync(1);
    chk_pub(6, 4);
    frame(4, 6, 10, -1, -1, 0, 0);
    model_pub(35);
    vsync(1);
    chk_pub(6, 4);
    repeat (5) @(negedge pixelclk);
    model_pub(0);
    vsync(1);
    chk_pub(0, 0);
    frame(4, 6, 10, -1, -1, 0, 1);
    model_pub(35);
    vsync(1);
    chk_pub(6, 4);
    frame(2, 6, 10, -1, -1, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_reset();
    @(negedge pixelclk);
    reset_n = 1'b1;
    frame(2, 6, 10, 0, 0, 245, 0);
    vsync(0);
    chk("rearm_atmos", o_atmos, 255);
    chk("rearm_valid", o_atmos_valid, 0);
    chk("rearm_cnt", o_frame_cnt, 0);
    frame(4, 6, 10, 1, 1, 200, 0);
    model_pub(200);
    vsync(1);
    chk_pub(6, 4);
    frame(3, 5, 10, 0, 4, 240, 0);
    model_pub(240);
    vsync(1);
    chk_pub(5, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
